pulse_scheduler: RTL and testbench

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

---
 rtl/pulse_scheduler.sv | 139 +++++++++++++
 tb/tb_pulse_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
// pulse_scheduler: time-triggered command issuer.
// Commands are queued with a due timestamp. While running, the FIFO head
// is issued to the pulser once the free-running time counter reaches its
// timestamp. Due and overdue are judged wrap-aware, as a signed difference.
//
// Ports
//   clk, rst        : rising-edge clock, async active-high reset
//   sync_start      : enter RUN / restart time counter at 0
//   stop            : return to IDLE and flush the queue
//   in_cmd/in_time  : command word and its due time; in_valid/in_ready handshake
//   command/cstrobe : last issued command and its one-cycle qualifier
//   collision       : downstream collision indication
//   run, tnow, count: state, time counter, queue occupancy
//   late, coll_seen : sticky flags, cleared by clear
module pulse_scheduler #(
  parameter int unsigned tw    = 32,
  parameter int unsigned depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync_start,
  input  logic                   stop,
  input  logic [63:0]            in_cmd,
  input  logic [tw-1:0]          in_time,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [63:0]            command,
  output logic                   cstrobe,
  input  logic                   collision,
  output logic                   run,
  output logic [tw-1:0]          tnow,
  output logic [$clog2(depth):0] count,
  output logic                   late,
  output logic                   coll_seen,
  input  logic                   clear
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [tw-1:0]   tnow_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [63:0]     command_q;
  logic            cstrobe_q;
  logic            late_q;
  logic            coll_q;

  logic [63:0]     cmd_mem  [depth];
  logic [tw-1:0]   time_mem [depth];

  logic [tw-1:0]   diff;
  logic            head_due;
  logic            head_over;
  logic            push;
  logic            pop;

  // Head timing and handshake decisions; stop overrides both push and pop.
  always_comb begin
    diff      = time_mem[rd_ptr_q] - tnow_q;
    head_over = diff[tw-1];
    head_due  = (diff == '0) || head_over;
    push      = in_valid && (count_q < DEPTH_C) && !stop;
    pop       = (state_q == RUN) && (count_q != '0) && head_due && !stop;
  end

  // Queue storage; left unreset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr_q]  <= in_cmd;
      time_mem[wr_ptr_q] <= in_time;
    end
  end

  // Run/idle FSM, time counter, queue pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tnow_q    <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      command_q <= '0;
      cstrobe_q <= 1'b0;
      late_q    <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        tnow_q <= '0;
        if (!stop && sync_start) state_q <= RUN;
      end else begin
        if (stop) begin
          state_q <= IDLE;
          tnow_q  <= '0;
        end else if (sync_start) begin
          tnow_q <= '0;
        end else begin
          tnow_q <= tnow_q + tw'(1);
        end
      end

      if (stop) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (!push && pop) count_q <= count_q - CW'(1);
      end

      cstrobe_q <= pop;
      if (pop) command_q <= cmd_mem[rd_ptr_q];

      // Sticky flags: a new set takes priority over clear.
      late_q <= (pop && head_over) || (late_q && !clear);
      coll_q <= collision || (coll_q && !clear);
    end
  end

  assign in_ready  = (count_q < DEPTH_C);
  assign command   = command_q;
  assign cstrobe   = cstrobe_q;
  assign run       = (state_q == RUN);
  assign tnow      = tnow_q;
  assign count     = count_q;
  assign late      = late_q;
  assign coll_seen = coll_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: a tw=32 instance for most scenarios
// and a tw=8 instance for time-counter wrap.
module tb_pulse_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // tw=32 instance
  logic        sync_start, stop, in_valid, in_ready, cstrobe, collision;
  logic        run, late, coll_seen, clear;
  logic [63:0] in_cmd, command;
  logic [31:0] in_time, tnow;
  logic [3:0]  count;

  // tw=8 instance
  logic        w_sync_start, w_stop, w_in_valid, w_in_ready, w_cstrobe;
  logic        w_collision, w_run, w_late, w_coll_seen, w_clear;
  logic [63:0] w_in_cmd, w_command;
  logic [7:0]  w_in_time, w_tnow;
  logic [3:0]  w_count;

  int vec  = 0;
  int miss = 0;
  int n_strb;
  int k;
  logic [63:0] strb_t;
  logic [63:0] strb_cmd;

  pulse_scheduler #(.tw(32), .depth(8)) u_dut (
    .clk(clk), .rst(rst), .sync_start(sync_start), .stop(stop),
    .in_cmd(in_cmd), .in_time(in_time), .in_valid(in_valid),
    .in_ready(in_ready), .command(command), .cstrobe(cstrobe),
    .collision(collision), .run(run), .tnow(tnow), .count(count),
    .late(late), .coll_seen(coll_seen), .clear(clear)
  );

  pulse_scheduler #(.tw(8), .depth(8)) u_dut8 (
    .clk(clk), .rst(rst), .sync_start(w_sync_start), .stop(w_stop),
    .in_cmd(w_in_cmd), .in_time(w_in_time), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .command(w_command), .cstrobe(w_cstrobe),
    .collision(w_collision), .run(w_run), .tnow(w_tnow), .count(w_count),
    .late(w_late), .coll_seen(w_coll_seen), .clear(w_clear)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    sync_start = 0; stop = 0; in_valid = 0; collision = 0; clear = 0;
    in_cmd = '0; in_time = '0;
    w_sync_start = 0; w_stop = 0; w_in_valid = 0; w_collision = 0; w_clear = 0;
    w_in_cmd = '0; w_in_time = '0;
    step(); step();

    // Reset values
    chk("rst_tnow", 64'(tnow), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_cmd", command, 64'd0);
    chk("rst_strb", 64'(cstrobe), 64'd0);
    chk("rst_run", 64'(run), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    step();

    // Single entry, time 10, pushed in IDLE
    in_valid = 1; in_cmd = 64'hA5; in_time = 32'd10;
    step();
    in_valid = 0;
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_idle_tnow", 64'(tnow), 64'd0);
    sync_start = 1;
    step();
    sync_start = 0;
    chk("t1_run", 64'(run), 64'd1);
    chk("t1_tnow0", 64'(tnow), 64'd0);
    n_strb = 0; strb_t = '0; strb_cmd = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cstrobe) begin n_strb++; strb_t = 64'(tnow); strb_cmd = command; end
    end
    chk("t1_nstrb", 64'(n_strb), 64'd1);
    chk("t1_strb_t", strb_t, 64'd11);
    chk("t1_cmd", strb_cmd, 64'hA5);
    chk("t1_late", 64'(late), 64'd0);
    chk("t1_hold", command, 64'hA5);
    stop = 1;
    step();
    stop = 0;
    chk("t1_stop_run", 64'(run), 64'd0);

    // Fill to depth in IDLE, refused 9th push, then back-to-back issue
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_cmd = 64'h100 + 64'(i); in_time = 32'd100 + 32'(i);
      step();
    end
    chk("t2_count8", 64'(count), 64'd8);
    chk("t2_ready0", 64'(in_ready), 64'd0);
    in_cmd = 64'hDEAD; in_time = 32'd50;
    step();
    in_valid = 0;
    chk("t2_refused", 64'(count), 64'd8);
    sync_start = 1;
    step();
    sync_start = 0;
    k = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (cstrobe) begin
        chk("t2_cmd", command, 64'h100 + 64'(k));
        chk("t2_tnow", 64'(tnow), 64'd101 + 64'(k));
        k++;
      end
    end
    chk("t2_nstrb", 64'(k), 64'd8);
    chk("t2_empty", 64'(count), 64'd0);
    chk("t2_late", 64'(late), 64'd0);

    // Overdue push at tnow=20, then clear
    sync_start = 1;
    step();
    sync_start = 0;
    chk("t3_restart", 64'(tnow), 64'd0);
    for (int i = 0; i < 20; i++) step();
    chk("t3_tnow20", 64'(tnow), 64'd20);
    in_valid = 1; in_cmd = 64'h33; in_time = 32'd3;
    step();
    in_valid = 0;
    chk("t3_nostrb", 64'(cstrobe), 64'd0);
    step();
    chk("t3_strb", 64'(cstrobe), 64'd1);
    chk("t3_cmd", command, 64'h33);
    chk("t3_late", 64'(late), 64'd1);
    clear = 1;
    step();
    clear = 0;
    chk("t3_clear", 64'(late), 64'd0);
    chk("t3_single", 64'(cstrobe), 64'd0);

    // Stop flushes queue
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_cmd = 64'h200 + 64'(i); in_time = 32'd1000;
      step();
    end
    in_valid = 0;
    chk("t4_count3", 64'(count), 64'd3);
    stop = 1;
    step();
    stop = 0;
    chk("t4_strb", 64'(cstrobe), 64'd0);
    chk("t4_count0", 64'(count), 64'd0);
    chk("t4_tnow0", 64'(tnow), 64'd0);
    chk("t4_idle", 64'(run), 64'd0);

    // Async reset mid-RUN with entries pending and coll_seen set
    sync_start = 1;
    step();
    sync_start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_cmd = 64'h300 + 64'(i); in_time = 32'd500;
      collision = (i == 2);
      step();
    end
    in_valid = 0; collision = 0;
    chk("t5_coll", 64'(coll_seen), 64'd1);
    chk("t5_pending", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_run", 64'(run), 64'd0);
    chk("t5_rst_tnow", 64'(tnow), 64'd0);
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_cmd", command, 64'd0);
    chk("t5_rst_coll", 64'(coll_seen), 64'd0);
    chk("t5_rst_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    step();
    chk("t5_rel_strb", 64'(cstrobe), 64'd0);
    chk("t5_rel_count", 64'(count), 64'd0);

    // Collision together with clear: set wins
    collision = 1; clear = 1;
    step();
    collision = 0; clear = 0;
    chk("t6_coll_win", 64'(coll_seen), 64'd1);
    clear = 1;
    step();
    clear = 0;
    chk("t6_clear", 64'(coll_seen), 64'd0);

    // tw=8: push time 4 at tnow 250, issued after wrap
    w_sync_start = 1;
    step();
    w_sync_start = 0;
    chk("w_run", 64'(w_run), 64'd1);
    for (int i = 0; i < 250; i++) step();
    chk("w_tnow250", 64'(w_tnow), 64'd250);
    w_in_valid = 1; w_in_cmd = 64'h77; w_in_time = 8'd4;
    step();
    w_in_valid = 0;
    chk("w_count1", 64'(w_count), 64'd1);
    chk("w_ready", 64'(w_in_ready), 64'd1);
    n_strb = 0; strb_t = '0; strb_cmd = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (w_cstrobe) begin n_strb++; strb_t = 64'(w_tnow); strb_cmd = w_command; end
    end
    chk("w_nstrb", 64'(n_strb), 64'd1);
    chk("w_strb_t", strb_t, 64'd5);
    chk("w_cmd", strb_cmd, 64'h77);
    chk("w_late", 64'(w_late), 64'd0);
    chk("w_coll", 64'(w_coll_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
